// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared types and default constants for the instruction/data RAM arbiter.
//   arb_state_t : arbiter FSM states (IDLE, IACC, DACC, RESP)
//   word_t      : processor data word
//   addr_t      : processor byte address
//   DEF_*       : default parameter values used by the interface and the top
package mem_arbiter_pkg;

  localparam int DEF_AW       = 32;
  localparam int DEF_DW       = 32;
  localparam int DEF_MAX_DRUN = 4;
  localparam int DEF_TIMEOUT  = 64;

  typedef logic [DEF_DW-1:0] word_t;
  typedef logic [DEF_AW-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    RESP = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the requester ports (instruction fetch and data) together with the
// RAM ports of the arbiter.
//   modport slave  : the arbiter's view (takes requests, drives the RAM)
//   modport master : the environment's view (issues requests, acts as RAM)
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) ();

  // requester side
  logic          iREN;
  logic [AW-1:0] iaddr;
  logic          dREN;
  logic          dWEN;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dstore;
  logic          ihit;
  logic [DW-1:0] iload;
  logic          dhit;
  logic [DW-1:0] dload;
  logic          err;

  // RAM side
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload;
  logic          ram_done;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_done,
    output ihit, iload, dhit, dload, err, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_done,
    input  ihit, iload, dhit, dload, err, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter_arb_priority.sv
// arb_priority
// Combinational grant policy: data requests win unless an instruction request
// is pending and the data side has already used up its run of grants.
//   iren_i     : instruction read request
//   dreq_i     : data request (read or write)
//   drun_max_i : starvation counter has reached its limit
//   grant_i_o  : grant the instruction side
//   grant_d_o  : grant the data side
module arb_priority (
  input  logic iren_i,
  input  logic dreq_i,
  input  logic drun_max_i,
  output logic grant_i_o,
  output logic grant_d_o
);

  assign grant_d_o = dreq_i & ~(iren_i & drun_max_i);
  assign grant_i_o = iren_i & ~grant_d_o;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-ported RAM between instruction fetch and data access.
// A granted request is latched into the RAM-side registers and held until
// ram_done (or watchdog expiry); a one-cycle RESP state then returns the hit.
//   CLK, RST : clock (rising edge), asynchronous active-high reset
//   bus      : mem_arbiter_if.slave carrying requester and RAM signals
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_DRUN = DEF_MAX_DRUN,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);

  localparam int DRW = $clog2(MAX_DRUN + 1);
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t    state_q;
  logic [DRW-1:0] drun_q, drun_d;
  logic [WDW-1:0] wdog_q;
  logic          ihit_q, dhit_q, err_q;
  logic [DW-1:0] iload_q, dload_q;
  // The RAM-side registers double as the latched address, op and store data.
  logic          ramREN_q, ramWEN_q;
  logic [AW-1:0] ramaddr_q;
  logic [DW-1:0] ramstore_q;

  logic dreq, drun_max, grant_i, grant_d, expire;

  assign dreq     = bus.dREN | bus.dWEN;
  assign drun_max = (drun_q == DRW'(MAX_DRUN));
  assign expire   = (wdog_q == WDW'(TIMEOUT - 1));

  arb_priority u_prio (
    .iren_i     (bus.iREN),
    .dreq_i     (dreq),
    .drun_max_i (drun_max),
    .grant_i_o  (grant_i),
    .grant_d_o  (grant_d)
  );

  // Starvation counter next value; only committed when arbitrating in IDLE.
  always_comb begin
    // NOTE: default first so every path assigns drun_d and no latch is inferred.
    drun_d = drun_q;
    if (grant_i) begin
      drun_d = '0;
    end else if (grant_d) begin
      if (!bus.iREN)     drun_d = '0;
      else if (!drun_max) drun_d = drun_q + DRW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values; every register, load latches included, is reset so
  // all outputs read 0 while RST is high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      drun_q     <= '0;
      wdog_q     <= '0;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      err_q      <= 1'b0;
      iload_q    <= '0;
      dload_q    <= '0;
      ramREN_q   <= 1'b0;
      ramWEN_q   <= 1'b0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
    end else begin
      ihit_q <= 1'b0;
      dhit_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          drun_q <= drun_d;
          wdog_q <= '0;
          if (grant_d) begin
            state_q    <= DACC;
            ramaddr_q  <= bus.daddr;
            ramstore_q <= bus.dstore;
            // dREN and dWEN together is treated as a write.
            ramWEN_q   <= bus.dWEN;
            ramREN_q   <= ~bus.dWEN;
          end else if (grant_i) begin
            state_q    <= IACC;
            ramaddr_q  <= bus.iaddr;
            ramstore_q <= '0;
            ramWEN_q   <= 1'b0;
            ramREN_q   <= 1'b1;
          end
        end
        IACC, DACC: begin
          if (bus.ram_done || expire) begin
            state_q    <= RESP;
            ramREN_q   <= 1'b0;
            ramWEN_q   <= 1'b0;
            ramaddr_q  <= '0;
            ramstore_q <= '0;
            // A completion in the expiry cycle still counts as normal.
            err_q      <= ~bus.ram_done;
            if (state_q == IACC) begin
              ihit_q  <= 1'b1;
              iload_q <= bus.ram_done ? bus.ramload : '0;
            end else begin
              dhit_q <= 1'b1;
              if (!bus.ram_done)  dload_q <= '0;
              else if (ramREN_q)  dload_q <= bus.ramload;
            end
          end else begin
            wdog_q <= wdog_q + WDW'(1);
          end
        end
        // One cycle for the requester to drop its served request.
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ihit     = ihit_q;
  assign bus.iload    = iload_q;
  assign bus.dhit     = dhit_q;
  assign bus.dload    = dload_q;
  assign bus.err      = err_q;
  assign bus.ramREN   = ramREN_q;
  assign bus.ramWEN   = ramWEN_q;
  assign bus.ramaddr  = ramaddr_q;
  assign bus.ramstore = ramstore_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with MAX_DRUN=4, TIMEOUT=8. The bench plays
// both requesters and the RAM; inputs change and outputs are sampled on the
// falling clock edge.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(
    .MAX_DRUN (4),
    .TIMEOUT  (8),
    .AW       (32),
    .DW       (32)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  // Bounded wait for a RAM strobe to appear.
  task automatic wait_grant(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.ramREN || bus.ramWEN) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, "_grant_wait"}, 0, 1);
  endtask

  // Serve one access as the RAM: expect a grant at exp_addr, complete it after
  // lat cycles, then check the hit lands on the expected side.
  task automatic do_access(input bit exp_d, input logic [31:0] exp_addr, input bit exp_wr,
                           input logic [31:0] rdata, input int lat, input bit drop,
                           input string tag);
    bit ok;
    wait_grant(tag, ok);
    if (!ok) return;
    check({tag, "_addr"}, bus.ramaddr, exp_addr);
    check({tag, "_wen"}, bus.ramWEN, exp_wr);
    check({tag, "_ren"}, bus.ramREN, !exp_wr);
    repeat (lat - 1) step();
    bus.ram_done = 1'b1;
    bus.ramload  = rdata;
    step();
    bus.ram_done = 1'b0;
    bus.ramload  = '0;
    check({tag, "_ihit"}, bus.ihit, !exp_d);
    check({tag, "_dhit"}, bus.dhit, exp_d);
    check({tag, "_err"}, bus.err, 0);
    if (!exp_wr) check({tag, "_load"}, exp_d ? bus.dload : bus.iload, rdata);
    if (drop) begin
      if (exp_d) begin
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
      end else begin
        bus.iREN = 1'b0;
      end
    end
  endtask

  initial begin
    int pulses;
    bit ok;
    bit expd;

    RST          = 1'b1;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ram_done = 1'b0;
    repeat (2) step();

    // reset state
    check("rst_ihit",    bus.ihit,    0);
    check("rst_dhit",    bus.dhit,    0);
    check("rst_err",     bus.err,     0);
    check("rst_ramren",  bus.ramREN,  0);
    check("rst_ramwen",  bus.ramWEN,  0);
    check("rst_ramaddr", bus.ramaddr, 0);
    check("rst_iload",   bus.iload,   0);
    check("rst_dload",   bus.dload,   0);
    RST = 1'b0;
    step();

    // instruction read, ram_done at cycle 3
    bus.iaddr = 32'h40;
    bus.iREN  = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      check($sformatf("t1_ren_c%0d", c), bus.ramREN, 1);
      check($sformatf("t1_addr_c%0d", c), bus.ramaddr, 32'h40);
      check($sformatf("t1_ihit_c%0d", c), bus.ihit, 0);
    end
    bus.ram_done = 1'b1;
    bus.ramload  = 32'h8C01_0004;
    step();
    bus.ram_done = 1'b0;
    bus.ramload  = '0;
    check("t1_ihit_c4",  bus.ihit,   1);
    check("t1_iload_c4", bus.iload,  32'h8C01_0004);
    check("t1_err_c4",   bus.err,    0);
    check("t1_ren_c4",   bus.ramREN, 0);
    bus.iREN = 1'b0;
    step();
    check("t1_ihit_c5", bus.ihit,   0);
    check("t1_ren_c5",  bus.ramREN, 0);

    // data write; store data latched, requester change ignored
    bus.daddr  = 32'h100;
    bus.dstore = 32'hDEAD_BEEF;
    bus.dWEN   = 1'b1;
    step();
    check("t2_wen",   bus.ramWEN,   1);
    check("t2_ren",   bus.ramREN,   0);
    check("t2_addr",  bus.ramaddr,  32'h100);
    check("t2_store", bus.ramstore, 32'hDEAD_BEEF);
    bus.dstore = 32'h1234_5678;
    step();
    check("t2_store_held", bus.ramstore, 32'hDEAD_BEEF);
    bus.ram_done = 1'b1;
    step();
    bus.ram_done = 1'b0;
    check("t2_dhit",  bus.dhit,   1);
    check("t2_err",   bus.err,    0);
    check("t2_iload", bus.iload,  32'h8C01_0004);
    check("t2_wen_off", bus.ramWEN, 0);
    bus.dWEN = 1'b0;
    pulses = 0;
    repeat (4) begin
      step();
      pulses += int'(bus.dhit);
    end
    check("t2_dhit_single", pulses, 0);

    // simultaneous requests: data first, then instruction, no re-issue
    bus.iaddr = 32'h200;
    bus.daddr = 32'h300;
    bus.iREN  = 1'b1;
    bus.dREN  = 1'b1;
    do_access(1'b1, 32'h300, 1'b0, 32'hAAAA_0001, 2, 1'b1, "t3_d");
    do_access(1'b0, 32'h200, 1'b0, 32'hBBBB_0002, 2, 1'b1, "t3_i");
    pulses = 0;
    repeat (4) begin
      step();
      pulses += int'(bus.ramREN | bus.ramWEN);
    end
    check("t3_no_reissue", pulses, 0);

    // starvation: both held, expected order D,D,D,D,I,D,D,D,D,I
    bus.iaddr = 32'h400;
    bus.daddr = 32'h800;
    bus.iREN  = 1'b1;
    bus.dREN  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      expd = (k % 5) != 4;
      do_access(expd, expd ? 32'h800 : 32'h400, 1'b0, 32'hC000_0000 | k, 1, 1'b0,
                $sformatf("t4_g%0d", k));
    end
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    step();

    // watchdog expiry: hit with err exactly 8 cycles after DACC entry
    bus.daddr = 32'h500;
    bus.dREN  = 1'b1;
    wait_grant("t5", ok);
    repeat (7) step();
    check("t5_dhit_c8", bus.dhit,   0);
    check("t5_ren_c8",  bus.ramREN, 1);
    step();
    check("t5_dhit_c9",  bus.dhit,   1);
    check("t5_err_c9",   bus.err,    1);
    check("t5_dload_c9", bus.dload,  0);
    check("t5_ren_c9",   bus.ramREN, 0);
    bus.dREN = 1'b0;
    step();
    check("t5_dhit_idle", bus.dhit,   0);
    check("t5_err_idle",  bus.err,    0);
    check("t5_ren_idle",  bus.ramREN, 0);

    // ram_done in the expiry cycle wins: normal completion
    bus.daddr = 32'h504;
    bus.dREN  = 1'b1;
    wait_grant("t5b", ok);
    repeat (7) step();
    bus.ram_done = 1'b1;
    bus.ramload  = 32'h55AA_55AA;
    step();
    bus.ram_done = 1'b0;
    bus.ramload  = '0;
    check("t5b_dhit",  bus.dhit,  1);
    check("t5b_err",   bus.err,   0);
    check("t5b_dload", bus.dload, 32'h55AA_55AA);
    bus.dREN = 1'b0;
    step();

    // reset during IACC abandons the access
    bus.iaddr = 32'h600;
    bus.iREN  = 1'b1;
    wait_grant("t6", ok);
    check("t6_ren_before", bus.ramREN, 1);
    #1 RST = 1'b1;
    #1;
    check("t6_ren_rst",   bus.ramREN,  0);
    check("t6_addr_rst",  bus.ramaddr, 0);
    check("t6_iload_rst", bus.iload,   0);
    check("t6_dload_rst", bus.dload,   0);
    pulses = 0;
    repeat (3) begin
      step();
      pulses += int'(bus.ihit);
    end
    check("t6_no_ihit", pulses, 0);
    bus.iREN = 1'b0;
    RST      = 1'b0;
    step();
    bus.iaddr = 32'h640;
    bus.iREN  = 1'b1;
    do_access(1'b0, 32'h640, 1'b0, 32'h0BAD_F00D, 2, 1'b1, "t6_fresh");
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported RAM between the instruction-fetch requester and the data requester of the pipelined processor.
- Sits between the datapath/cache request ports and the RAM.
- Each request is latched into a registered access state. RAM control is held stable until the RAM signals completion, then a one-cycle hit is returned.
- Data requests have priority. A starvation counter forces an instruction grant after a bounded run of data grants.
- A watchdog aborts accesses the RAM never completes.

Parameters:
- MAX_DRUN, 4: consecutive data grants allowed while an instruction request is pending; the next grant goes to the instruction side.
- TIMEOUT, 64: cycles in an access state without ram_done before the access is aborted.
- AW, 32: address width.
- DW, 32: data word width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- iREN  in  1  instruction read request; held until ihit.
- iaddr  in  AW  instruction address.
- dREN  in  1  data read request; held until dhit.
- dWEN  in  1  data write request; held until dhit; mutually exclusive with dREN.
- daddr  in  AW  data address.
- dstore  in  DW  write data.
- ihit  out  1  one-cycle instruction completion pulse.
- iload  out  DW  registered instruction word, valid when ihit=1.
- dhit  out  1  one-cycle data completion pulse.
- dload  out  DW  registered read data, valid when dhit=1 for a read.
- err  out  1  one-cycle pulse, coincident with the hit of an aborted access.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  AW  RAM address.
- ramstore  out  DW  RAM write data.
- ramload  in  DW  RAM read data, valid with ram_done.
- ram_done  in  1  RAM completion, one cycle.

Behaviour:
- Reset: state=IDLE; all outputs 0; drun=0; wdog=0; latched address/data/op cleared. Reset mid-access abandons the access immediately; no hit is issued.
- States and transitions:
  - IDLE: RAM strobes 0.
    - Data request (dREN|dWEN) with drun<MAX_DRUN, or data request with no iREN → DACC.
    - iREN with no data request, or iREN with drun==MAX_DRUN → IACC.
    - Neither → stay in IDLE.
    - On entry to an access state, latch addr, op and store data from the winning requester.
  - IACC: ramREN=1, ramaddr=latched iaddr.
  - DACC: ramREN/ramWEN per latched op, ramaddr=latched daddr, ramstore=latched dstore.
  - In either access state:
    - RAM outputs come only from latched values; requester changes are ignored.
    - ram_done → RESP; for a read, capture ramload into iload/dload.
  - RESP: exactly one cycle. ihit or dhit =1 per the served side; strobes 0. Then → IDLE.
    - RESP exists so the requester can drop or replace its request before the next arbitration; a held stale request is never re-issued.
- Latency:
  - Request visible in IDLE at cycle 0 → strobes asserted from cycle 1.
  - ram_done at cycle k → hit at cycle k+1 → IDLE at k+2.
  - Minimum 3 cycles per access.
- Starvation counter drun (width clog2(MAX_DRUN+1)):
  - Incremented on each data grant while iREN=1.
  - Cleared on any instruction grant, or on a data grant while iREN=0.
  - Saturates at MAX_DRUN.
- Simultaneous events:
  - iREN and dREN/dWEN together, drun<MAX_DRUN → data wins.
  - dREN and dWEN both 1 is illegal; treat as write.
- Watchdog wdog:
  - Cleared on entry to IACC/DACC; increments each access-state cycle without ram_done.
  - wdog==TIMEOUT-1 without ram_done → RESP with err=1, hit asserted, load output =0.
  - ram_done in the same cycle as expiry takes precedence: normal completion, err=0.
- iload/dload hold their value outside RESP. The value is undefined to consumers, but the RTL keeps the last value.

Decomposition:
- Shared package (cpu_types_pkg extension): arb_state_t enum {IDLE, IACC, DACC, RESP}; word_t reuse; default constants for MAX_DRUN and TIMEOUT.
- One natural sub-module: arb_priority. It is combinational and takes iREN, dreq and drun==MAX_DRUN, returning grant_i/grant_d. This isolates the policy for unit testing.
- FSM, counters and latches stay in mem_arbiter.

Test Plan:
- Instruction read only: iREN=1, iaddr=0x40, ram_done at cycle 3 with ramload=0x8C010004.
  - Required: ramREN=1, ramaddr=0x40 during cycles 1-3; ihit=1 with iload=0x8C010004 at cycle 4; IDLE at 5.
- Data write: dWEN=1, daddr=0x100, dstore=0xDEADBEEF.
  - Required: ramWEN=1, ramstore=0xDEADBEEF held until ram_done; dhit pulses once; iload unchanged.
- Simultaneous iREN and dREN with drun=0.
  - Required: DACC first, dhit; then IACC, ihit; no duplicate RAM access from held requests.
- Starvation, MAX_DRUN=4: dREN and iREN held continuously, RAM done after 1 cycle each.
  - Required grant order D,D,D,D,I,D,…; drun returns to 0 after the I grant.
- Timeout, TIMEOUT=8: dREN=1, ram_done never asserted.
  - Required: dhit=1, err=1, dload=0 exactly 8 cycles after DACC entry; then IDLE.
- RST asserted during IACC.
  - Required: all outputs 0 asynchronously, no ihit; after release, a fresh iREN is served normally.
